// File: rtl/cp0_exc_seq.sv
// cp0_exc_seq: exception/interrupt entry and ERET sequencer for the OpenMIPS core.
// Sits between MEM and the CP0 register block. It arbitrates pending exceptions,
// flushes the pipeline, and writes EPC, then Cause, then Status through the single
// CP0 write port. It then redirects the PC to EXC_VECTOR, or to EPC for ERET.
// Optional feature macro: EXC_TRAP_EN (trap exception, ExcCode 13).
// All outputs come straight from flops: they are decoded from the next state and
// the next latch contents, so they line up with the registered state.
module cp0_exc_seq #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic        exc_ri_i,
    input  logic        exc_sys_i,
    input  logic        exc_bp_i,
    input  logic        exc_ov_i,
    input  logic        exc_tr_i,
    input  logic        eret_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_data_i,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_data_o,
    output logic        cp0_exc_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        pc_we_o,
    output logic [31:0] new_pc_o
);

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_EPC   = 3'd1,
        W_CAUSE = 3'd2,
        W_STAT  = 3'd3,
        REDIR   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic [31:0] stat_q, stat_d;
    logic [31:0] epc_q, epc_d;
    logic        eret_q, eret_d;

    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] data_q, data_d;
    logic        exc_q, exc_d;
    logic        flush_q, flush_d;
    logic        stall_q, stall_d;
    logic        pc_we_q, pc_we_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic [31:0] eff_status_s;
    logic [31:0] eff_cause_s;
    logic [31:0] eff_epc_s;
    logic        int_pend_s;
    logic        exc_hit_s;
    logic [4:0]  exc_code_s;

    // Only Cause.IP is consumed; the other Cause bits are deliberately dropped.
`ifdef EXC_TRAP_EN
    logic cause_unused_s;
    assign cause_unused_s = ^{cause_i[31:16], cause_i[7:0]};
`else
    logic cause_unused_s;
    assign cause_unused_s = ^{cause_i[31:16], cause_i[7:0], exc_tr_i};
`endif

    // Return address: the branch owning the delay slot, 32-bit wraparound.
    function automatic logic [31:0] epc_value(input logic [31:0] pc, input logic bd);
        epc_value = bd ? (pc - 32'd4) : pc;
    endfunction

    // Forward a pending WB write to CP0 so the sequencer sees current register values.
    always_comb begin
        eff_status_s = status_i;
        eff_cause_s  = cause_i;
        eff_epc_s    = epc_i;
        if (wb_we_i && (wb_waddr_i == ADDR_STATUS)) begin
            eff_status_s = wb_data_i;
        end else begin
            eff_status_s = status_i;
        end
        if (wb_we_i && (wb_waddr_i == ADDR_CAUSE)) begin
            eff_cause_s = wb_data_i;
        end else begin
            eff_cause_s = cause_i;
        end
        if (wb_we_i && (wb_waddr_i == ADDR_EPC)) begin
            eff_epc_s = wb_data_i;
        end else begin
            eff_epc_s = epc_i;
        end
    end

    // Arbitrate the MEM-stage exception sources by priority and pick the ExcCode.
    always_comb begin
        int_pend_s = valid_i && ((eff_cause_s[15:8] & eff_status_s[15:8]) != 8'd0)
                     && eff_status_s[0] && !eff_status_s[1];
        exc_hit_s  = 1'b1;
        exc_code_s = 5'd0;
        if (int_pend_s) begin
            exc_code_s = 5'd0;
        end else if (valid_i && exc_ri_i) begin
            exc_code_s = 5'd10;
        end else if (valid_i && exc_sys_i) begin
            exc_code_s = 5'd8;
        end else if (valid_i && exc_bp_i) begin
            exc_code_s = 5'd9;
`ifdef EXC_TRAP_EN
        end else if (valid_i && exc_tr_i) begin
            exc_code_s = 5'd13;
`endif
        end else if (valid_i && exc_ov_i) begin
            exc_code_s = 5'd12;
        end else begin
            exc_hit_s  = 1'b0;
            exc_code_s = 5'd0;
        end
    end

    // Next state and latch contents; requests are only accepted in IDLE.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pc_d    = pc_q;
        bd_d    = bd_q;
        stat_d  = stat_q;
        epc_d   = epc_q;
        eret_d  = eret_q;
        case (state_q)
            IDLE: begin
                if (exc_hit_s) begin
                    state_d = W_EPC;
                    code_d  = exc_code_s;
                    pc_d    = pc_i;
                    bd_d    = in_delayslot_i;
                    stat_d  = eff_status_s;
                    eret_d  = 1'b0;
                end else if (valid_i && eret_i) begin
                    state_d = W_STAT;
                    stat_d  = eff_status_s;
                    epc_d   = eff_epc_s;
                    eret_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            W_EPC:   state_d = W_CAUSE;
            W_CAUSE: state_d = W_STAT;
            W_STAT:  state_d = REDIR;
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode outputs for the coming cycle so they can be registered.
    always_comb begin
        we_d     = 1'b0;
        waddr_d  = 5'd0;
        data_d   = 32'd0;
        exc_d    = 1'b0;
        flush_d  = 1'b0;
        stall_d  = 1'b1;
        pc_we_d  = 1'b0;
        new_pc_d = 32'd0;
        case (state_d)
            IDLE: begin
                stall_d = 1'b0;
            end
            W_EPC: begin
                flush_d = 1'b1;
                we_d    = 1'b1;
                waddr_d = ADDR_EPC;
                data_d  = epc_value(pc_d, bd_d);
            end
            W_CAUSE: begin
                we_d    = 1'b1;
                waddr_d = ADDR_CAUSE;
                data_d  = {bd_d, 24'd0, code_d, 2'b00};
                exc_d   = 1'b1;
            end
            W_STAT: begin
                we_d    = 1'b1;
                waddr_d = ADDR_STATUS;
                if (eret_d) begin
                    data_d  = stat_d & ~32'h0000_0002;
                    flush_d = 1'b1;
                end else begin
                    data_d  = stat_d | 32'h0000_0002;
                end
            end
            REDIR: begin
                pc_we_d = 1'b1;
                if (eret_d) begin
                    new_pc_d = epc_d;
                end else begin
                    new_pc_d = EXC_VECTOR;
                end
            end
            default: begin
                stall_d = 1'b0;
            end
        endcase
    end

    // State, latches and output flops; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            code_q   <= 5'd0;
            pc_q     <= 32'd0;
            bd_q     <= 1'b0;
            stat_q   <= 32'd0;
            epc_q    <= 32'd0;
            eret_q   <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= 5'd0;
            data_q   <= 32'd0;
            exc_q    <= 1'b0;
            flush_q  <= 1'b0;
            stall_q  <= 1'b0;
            pc_we_q  <= 1'b0;
            new_pc_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            pc_q     <= pc_d;
            bd_q     <= bd_d;
            stat_q   <= stat_d;
            epc_q    <= epc_d;
            eret_q   <= eret_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            data_q   <= data_d;
            exc_q    <= exc_d;
            flush_q  <= flush_d;
            stall_q  <= stall_d;
            pc_we_q  <= pc_we_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign cp0_we_o    = we_q;
    assign cp0_waddr_o = waddr_q;
    assign cp0_data_o  = data_q;
    assign cp0_exc_o   = exc_q;
    assign flush_o     = flush_q;
    assign stall_o     = stall_q;
    assign pc_we_o     = pc_we_q;
    assign new_pc_o    = new_pc_q;

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Directed testbench for cp0_exc_seq. A cycle-level model queues the expected
// output pattern of each accepted request; a compare process checks every cycle.
module tb_cp0_exc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, in_delayslot_i;
    logic [31:0] pc_i, status_i, cause_i, epc_i, wb_data_i;
    logic        exc_ri_i, exc_sys_i, exc_bp_i, exc_ov_i, exc_tr_i, eret_i;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic        cp0_we_o, cp0_exc_o, flush_o, stall_o, pc_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_data_o, new_pc_o;

    int checks = 0;
    int errors = 0;

    cp0_exc_seq dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i),
        .in_delayslot_i(in_delayslot_i), .exc_ri_i(exc_ri_i), .exc_sys_i(exc_sys_i),
        .exc_bp_i(exc_bp_i), .exc_ov_i(exc_ov_i), .exc_tr_i(exc_tr_i), .eret_i(eret_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .wb_we_i(wb_we_i),
        .wb_waddr_i(wb_waddr_i), .wb_data_i(wb_data_i), .cp0_we_o(cp0_we_o),
        .cp0_waddr_o(cp0_waddr_o), .cp0_data_o(cp0_data_o), .cp0_exc_o(cp0_exc_o),
        .flush_o(flush_o), .stall_o(stall_o), .pc_we_o(pc_we_o), .new_pc_o(new_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        exc;
        logic        flush;
        logic        stall;
        logic        pc_we;
        logic [31:0] npc;
    } out_t;

    localparam out_t ZERO = '0;
    out_t exp_q[$];
    out_t exp_cur = '0;

    function automatic out_t mk(logic we, logic [4:0] a, logic [31:0] d, logic e,
                                logic f, logic p, logic [31:0] n);
        out_t o;
        o.we = we; o.addr = a; o.data = d; o.exc = e; o.flush = f;
        o.stall = 1'b1; o.pc_we = p; o.npc = n;
        return o;
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] a, logic [31:0] v);
        return (wb_we_i && wb_waddr_i == a) ? wb_data_i : v;
    endfunction

    // Model: decide what the sampled request is and queue its output pattern.
    always @(posedge clk) begin
        logic [31:0] st, ca, ep;
        int code;
        if (rst) begin
            exp_q.delete();
            exp_cur = ZERO;
        end else begin
            if (exp_q.size() == 0 && !exp_cur.stall && valid_i) begin
                st = fwd(5'd12, status_i);
                ca = fwd(5'd13, cause_i);
                ep = fwd(5'd14, epc_i);
                code = -1;
                if ((ca[15:8] & st[15:8]) != 8'd0 && st[0] && !st[1]) code = 0;
                else if (exc_ri_i) code = 10;
                else if (exc_sys_i) code = 8;
                else if (exc_bp_i) code = 9;
`ifdef EXC_TRAP_EN
                else if (exc_tr_i) code = 13;
`endif
                else if (exc_ov_i) code = 12;
                if (code >= 0) begin
                    exp_q.push_back(mk(1'b1, 5'd14, pc_i - (in_delayslot_i ? 32'd4 : 32'd0),
                                       1'b0, 1'b1, 1'b0, 32'd0));
                    exp_q.push_back(mk(1'b1, 5'd13,
                                       (in_delayslot_i ? 32'h8000_0000 : 32'd0) + 32'(code * 4),
                                       1'b1, 1'b0, 1'b0, 32'd0));
                    exp_q.push_back(mk(1'b1, 5'd12, st | 32'h2, 1'b0, 1'b0, 1'b0, 32'd0));
                    exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h20));
                end else if (eret_i) begin
                    exp_q.push_back(mk(1'b1, 5'd12, st & ~32'h2, 1'b0, 1'b1, 1'b0, 32'd0));
                    exp_q.push_back(mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, ep));
                end
            end
            exp_cur = (exp_q.size() != 0) ? exp_q.pop_front() : ZERO;
        end
    end

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        out_t act;
        act = {cp0_we_o, cp0_waddr_o, cp0_data_o, cp0_exc_o, flush_o, stall_o,
               pc_we_o, new_pc_o};
        checks++;
        if (act !== exp_cur) begin
            errors++;
            $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act, exp_cur);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic clr();
        valid_i = 1'b0; in_delayslot_i = 1'b0; pc_i = 32'd0;
        exc_ri_i = 1'b0; exc_sys_i = 1'b0; exc_bp_i = 1'b0; exc_ov_i = 1'b0;
        exc_tr_i = 1'b0; eret_i = 1'b0; wb_we_i = 1'b0; wb_waddr_i = 5'd0;
        wb_data_i = 32'd0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Directed stimulus with literal expectations at key cycles.
    initial begin
        int stalls;
        rst = 1'b1;
        clr();
        status_i = 32'd0; cause_i = 32'd0; epc_i = 32'd0;
        idle(2);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        chk("reset_we", {31'd0, cp0_we_o}, 32'd0);
        rst = 1'b0;
        idle(1);

        // SYS at 0x100, no delay slot
        status_i = 32'h0000_0010;
        valid_i = 1'b1; pc_i = 32'h100; exc_sys_i = 1'b1;
        @(negedge clk); clr();
        chk("sys_epc_addr", {27'd0, cp0_waddr_o}, 32'd14);
        chk("sys_epc_data", cp0_data_o, 32'h100);
        chk("sys_epc_flush", {31'd0, flush_o}, 32'd1);
        stalls = 0;
        if (stall_o) stalls++;
        @(negedge clk);
        chk("sys_cause_data", cp0_data_o, 32'h20);
        chk("sys_cause_exc", {31'd0, cp0_exc_o}, 32'd1);
        if (stall_o) stalls++;
        @(negedge clk);
        chk("sys_stat_data", cp0_data_o, 32'h12);
        if (stall_o) stalls++;
        @(negedge clk);
        chk("sys_redir_pc", new_pc_o, 32'h20);
        chk("sys_redir_we", {31'd0, pc_we_o}, 32'd1);
        if (stall_o) stalls++;
        @(negedge clk);
        if (stall_o) stalls++;
        chk("sys_stall_cycles", 32'(stalls), 32'd4);
        idle(1);

        // OV at 0x204 in delay slot
        valid_i = 1'b1; pc_i = 32'h204; in_delayslot_i = 1'b1; exc_ov_i = 1'b1;
        @(negedge clk); clr();
        chk("ov_epc", cp0_data_o, 32'h200);
        @(negedge clk);
        chk("ov_cause", cp0_data_o, 32'h8000_0030);
        idle(4);

        // Interrupt beats RI
        status_i = 32'h0000_FF01; cause_i = 32'h0000_0400;
        valid_i = 1'b1; pc_i = 32'h500; exc_ri_i = 1'b1;
        @(negedge clk); clr();
        chk("int_epc", cp0_data_o, 32'h500);
        @(negedge clk);
        chk("int_cause", cp0_data_o, 32'h0);
        idle(4);
        // With EXL set the interrupt is masked and RI is taken
        status_i = 32'h0000_FF03;
        valid_i = 1'b1; pc_i = 32'h504; exc_ri_i = 1'b1;
        @(negedge clk); clr();
        @(negedge clk);
        chk("ri_cause", cp0_data_o, 32'h28);
        idle(4);
        // Interrupt not evaluated without valid_i
        status_i = 32'h0000_FF01; valid_i = 1'b0;
        idle(3);
        chk("int_novalid_stall", {31'd0, stall_o}, 32'd0);
        status_i = 32'h0000_0012; cause_i = 32'd0;

        // ERET with EPC forwarded from WB
        epc_i = 32'h300;
        valid_i = 1'b1; eret_i = 1'b1; wb_we_i = 1'b1; wb_waddr_i = 5'd14; wb_data_i = 32'h400;
        @(negedge clk); clr();
        chk("eret_stat_data", cp0_data_o, 32'h10);
        chk("eret_flush", {31'd0, flush_o}, 32'd1);
        @(negedge clk);
        chk("eret_newpc", new_pc_o, 32'h400);
        idle(3);

        // Exception and ERET together, Status forwarded from WB
        valid_i = 1'b1; eret_i = 1'b1; exc_bp_i = 1'b1; pc_i = 32'h600;
        wb_we_i = 1'b1; wb_waddr_i = 5'd12; wb_data_i = 32'h0000_0040;
        @(negedge clk); clr();
        @(negedge clk);
        chk("bp_cause", cp0_data_o, 32'h24);
        @(negedge clk);
        chk("bp_stat_fwd", cp0_data_o, 32'h42);
        idle(3);

        // Reset during W_CAUSE
        valid_i = 1'b1; exc_sys_i = 1'b1; pc_i = 32'h700;
        @(negedge clk); clr();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_mid_we", {31'd0, cp0_we_o}, 32'd0);
        rst = 1'b0;
        valid_i = 1'b1; exc_sys_i = 1'b1; pc_i = 32'h704;
        @(negedge clk); clr();
        chk("rst_after_epc", cp0_data_o, 32'h704);
        idle(5);

        // Trap alone
        valid_i = 1'b1; exc_tr_i = 1'b1; pc_i = 32'h800;
        @(negedge clk); clr();
        @(negedge clk);
`ifdef EXC_TRAP_EN
        chk("trap_cause", cp0_data_o, 32'h34);
`else
        chk("trap_ignored", {31'd0, stall_o}, 32'd0);
`endif
        idle(4);

        // PC wraparound with BD at pc 0
        valid_i = 1'b1; exc_sys_i = 1'b1; pc_i = 32'h0; in_delayslot_i = 1'b1;
        @(negedge clk); clr();
        chk("wrap_epc", cp0_data_o, 32'hFFFF_FFFC);
        idle(5);

        // Back-to-back: request held high, model checks the idle gap
        valid_i = 1'b1; exc_ov_i = 1'b1; pc_i = 32'h900;
        idle(12);
        clr();
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
